ysyx_2022040010_sram_axi_bridge: RTL and testbench

//  Sits directly below the core top: converts the core's isram_*/dsram_* SRAM-style ports into one AXI4-Lite master.

---
 rtl/ysyx_2022040010_sram_axi_bridge_pkg.sv | 33 +++
 rtl/ysyx_2022040010_sram_axi_bridge_if.sv | 37 +++
 rtl/ysyx_2022040010_sram_axi_bridge_lsu_align.sv | 25 ++
 rtl/ysyx_2022040010_sram_axi_bridge.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_2022040010_sram_axi_bridge.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_2022040010_sram_axi_bridge_pkg.sv
// rtl/ysyx_2022040010_sram_axi_bridge_pkg.sv - shared constants, FSM state encoding and size-mask helper
// Contents: SEL_* size one-hots, AXI_OKAY response code, state_e FSM states, size_mask()
package ysyx_2022040010_sram_axi_bridge_pkg;

  localparam logic [3:0] SEL_B    = 4'b0001;
  localparam logic [3:0] SEL_H    = 4'b0010;
  localparam logic [3:0] SEL_W    = 4'b0100;
  localparam logic [3:0] SEL_D    = 4'b1000;
  localparam logic [1:0] AXI_OKAY = 2'b00;
  localparam int         RESP_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D_AR = 3'd1,
    S_D_R  = 3'd2,
    S_D_AW = 3'd3,
    S_D_B  = 3'd4,
    S_I_AR = 3'd5,
    S_I_R  = 3'd6,
    S_DONE = 3'd7
  } state_e;

  // Byte mask for the access size; the highest set bit wins so a malformed
  // sel still produces a defined size. No bits set -> no bytes written.
  function automatic logic [7:0] size_mask(input logic [3:0] sel);
    if ((sel & SEL_D) != 4'b0)      return 8'hFF;
    else if ((sel & SEL_W) != 4'b0) return 8'h0F;
    else if ((sel & SEL_H) != 4'b0) return 8'h03;
    else if ((sel & SEL_B) != 4'b0) return 8'h01;
    else                            return 8'h00;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_sram_axi_bridge_if.sv
// rtl/ysyx_2022040010_sram_axi_bridge_if.sv - AXI4-Lite channel bundle with master/slave views
// Signals: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready), B (bresp/bvalid/bready),
//          AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready)
interface ysyx_2022040010_sram_axi_bridge_if
  import ysyx_2022040010_sram_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [RESP_W-1:0]   bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [RESP_W-1:0]   rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_2022040010_sram_axi_bridge_lsu_align.sv
// rtl/ysyx_2022040010_sram_axi_bridge_lsu_align.sv - combinational byte-lane alignment for the bridge
// Ports: off_i (byte offset), sel_i (size), wdata_i/rdata_i (raw data), ihi_i (fetch addr[2])
//        -> wstrb_o, wdata_o (lane-shifted store), rdata_o (right-justified load), inst_o
module ysyx_2022040010_lsu_align
  import ysyx_2022040010_sram_axi_bridge_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [3:0]  sel_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  input  logic        ihi_i,
  output logic [7:0]  wstrb_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o,
  output logic [31:0] inst_o
);
  logic [5:0] shamt;

  assign shamt   = {off_i, 3'b000};
  // 8-bit result: strobe bits shifted past lane 7 are dropped, accesses are never split
  assign wstrb_o = size_mask(sel_i) << off_i;
  assign wdata_o = wdata_i << shamt;
  assign rdata_o = rdata_i >> shamt;
  assign inst_o  = ihi_i ? rdata_i[63:32] : rdata_i[31:0];
endmodule

// File: rtl/ysyx_2022040010_sram_axi_bridge.sv
// rtl/ysyx_2022040010_sram_axi_bridge.sv - serialises core fetch and load/store SRAM ports onto one AXI4-Lite master
// Ports: clk, rst (async, active-high); isram_e/addr/rdata (fetch); dsram_e/we/addr/wdata/sel/rdata (data);
//        cpu_stall (hold core), bus_err (error-response pulse); m (AXI4-Lite master)
module ysyx_2022040010_sram_axi_bridge
  import ysyx_2022040010_sram_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              isram_e,
  input  logic [ADDR_W-1:0] isram_addr,
  output logic [31:0]       isram_rdata,
  input  logic              dsram_e,
  input  logic              dsram_we,
  input  logic [ADDR_W-1:0] dsram_addr,
  input  logic [DATA_W-1:0] dsram_wdata,
  input  logic [3:0]        dsram_sel,
  output logic [DATA_W-1:0] dsram_rdata,
  output logic              cpu_stall,
  output logic              bus_err,
  ysyx_2022040010_sram_axi_bridge_if.master m
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              ie_q, ie_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic [31:0]       irdata_q, irdata_d;

  logic              arvalid, awvalid, wvalid, bready, rready;
  logic [ADDR_W-1:0] araddr;
  logic              aw_fin, w_fin;

  logic [7:0]        al_wstrb;
  logic [63:0]       al_wdata, al_rdata;
  logic [31:0]       al_inst;

  ysyx_2022040010_lsu_align u_align (
    .off_i   (daddr_q[2:0]),
    .sel_i   (sel_q),
    .wdata_i (wdata_q),
    .rdata_i (m.rdata),
    .ihi_i   (iaddr_q[2]),
    .wstrb_o (al_wstrb),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata),
    .inst_o  (al_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      daddr_q   <= '0;
      iaddr_q   <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      ie_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      drdata_q  <= '0;
      irdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      daddr_q   <= daddr_d;
      iaddr_q   <= iaddr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      ie_q      <= ie_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      drdata_q  <= drdata_d;
      irdata_q  <= irdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    daddr_d   = daddr_q;
    iaddr_d   = iaddr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    ie_d      = ie_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    drdata_d  = drdata_q;
    irdata_d  = irdata_q;
    arvalid   = 1'b0;
    araddr    = daddr_q & ALIGN_MASK;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rready    = 1'b0;
    bus_err   = 1'b0;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dsram_e | isram_e) begin
          daddr_d = dsram_addr;
          iaddr_d = isram_addr;
          wdata_d = dsram_wdata;
          sel_d   = dsram_sel;
          ie_d    = isram_e;
          // data side always goes first; the fetch follows from ie_q
          if (dsram_e) state_d = dsram_we ? S_D_AW : S_D_AR;
          else         state_d = S_I_AR;
        end
      end
      S_D_AR: begin
        arvalid = 1'b1;
        if (m.arready) state_d = S_D_R;
      end
      S_D_R: begin
        rready = 1'b1;
        if (m.rvalid) begin
          drdata_d = al_rdata;
          bus_err  = (m.rresp != AXI_OKAY);
          state_d  = ie_q ? S_I_AR : S_DONE;
        end
      end
      S_D_AW: begin
        // AW and W start together but complete independently
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        aw_fin  = aw_done_q | m.awready;
        w_fin   = w_done_q | m.wready;
        if (aw_fin & w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_D_B;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      S_D_B: begin
        bready = 1'b1;
        if (m.bvalid) begin
          bus_err = (m.bresp != AXI_OKAY);
          state_d = ie_q ? S_I_AR : S_DONE;
        end
      end
      S_I_AR: begin
        arvalid = 1'b1;
        araddr  = iaddr_q & ALIGN_MASK;
        if (m.arready) state_d = S_I_R;
      end
      S_I_R: begin
        rready = 1'b1;
        if (m.rvalid) begin
          irdata_d = al_inst;
          bus_err  = (m.rresp != AXI_OKAY);
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign m.awaddr  = daddr_q & ALIGN_MASK;
  assign m.awvalid = awvalid;
  assign m.wdata   = al_wdata;
  assign m.wstrb   = al_wstrb;
  assign m.wvalid  = wvalid;
  assign m.bready  = bready;
  assign m.araddr  = araddr;
  assign m.arvalid = arvalid;
  assign m.rready  = rready;

  assign isram_rdata = irdata_q;
  assign dsram_rdata = drdata_q;
  // combinational so the core sees the stall in the same cycle it raises a request
  assign cpu_stall   = (isram_e | dsram_e) & (state_q != S_DONE);
endmodule

// File: tb/tb_ysyx_2022040010_sram_axi_bridge.sv
// tb/tb_ysyx_2022040010_sram_axi_bridge.sv - directed bench for the SRAM-to-AXI4-Lite bridge
module tb_ysyx_2022040010_sram_axi_bridge;
  import ysyx_2022040010_sram_axi_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        isram_e = 1'b0, dsram_e = 1'b0, dsram_we = 1'b0;
  logic [63:0] isram_addr = '0, dsram_addr = '0, dsram_wdata = '0;
  logic [3:0]  dsram_sel = '0;
  logic [31:0] isram_rdata;
  logic [63:0] dsram_rdata;
  logic        cpu_stall, bus_err;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_2022040010_sram_axi_bridge_if m();

  ysyx_2022040010_sram_axi_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .isram_e     (isram_e),
    .isram_addr  (isram_addr),
    .isram_rdata (isram_rdata),
    .dsram_e     (dsram_e),
    .dsram_we    (dsram_we),
    .dsram_addr  (dsram_addr),
    .dsram_wdata (dsram_wdata),
    .dsram_sel   (dsram_sel),
    .dsram_rdata (dsram_rdata),
    .cpu_stall   (cpu_stall),
    .bus_err     (bus_err),
    .m           (m)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  int          ar_cnt, aw_cnt, w_cnt;
  logic [63:0] mem [0:511];
  logic        aw_got, w_got, rvalid_r, bvalid_r;
  logic [63:0] rdata_r, cap_awaddr, cap_wdata;
  logic [7:0]  cap_wstrb;
  logic [1:0]  rresp_r;
  logic [63:0] ar_log [$];

  assign m.arready = m.arvalid && (ar_cnt >= ar_delay);
  assign m.awready = m.awvalid && (aw_cnt >= aw_delay);
  assign m.wready  = m.wvalid && (w_cnt >= w_delay);
  assign m.rvalid  = rvalid_r;
  assign m.rdata   = rdata_r;
  assign m.rresp   = rresp_r;
  assign m.bvalid  = bvalid_r;
  assign m.bresp   = 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      rvalid_r <= 1'b0; bvalid_r <= 1'b0;
      rdata_r <= '0; rresp_r <= '0;
    end else begin
      ar_cnt <= (m.arvalid && !m.arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (m.awvalid && !m.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m.wvalid && !m.wready) ? w_cnt + 1 : 0;
      if (m.arvalid && m.arready) begin
        rvalid_r <= 1'b1;
        rdata_r  <= mem[m.araddr[11:3]];
        rresp_r  <= rresp_cfg;
        ar_log.push_back(m.araddr);
      end else if (rvalid_r && m.rready) begin
        rvalid_r <= 1'b0;
      end
      if (m.awvalid && m.awready) cap_awaddr <= m.awaddr;
      if (m.wvalid && m.wready) begin
        cap_wdata <= m.wdata;
        cap_wstrb <= m.wstrb;
      end
      if ((aw_got || (m.awvalid && m.awready)) && (w_got || (m.wvalid && m.wready))) begin
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        bvalid_r <= 1'b1;
        for (int b = 0; b < 8; b++)
          if (m.wstrb[b]) mem[m.awaddr[11:3]][8*b +: 8] <= m.wdata[8*b +: 8];
      end else begin
        if (m.awvalid && m.awready) aw_got <= 1'b1;
        if (m.wvalid && m.wready)   w_got  <= 1'b1;
      end
      if (bvalid_r && m.bready) bvalid_r <= 1'b0;
    end
  end

  // ---------------- stimulus helper ----------------
  logic av_log [0:63];
  logic wv_log [0:63];

  // Presents one request in the cycle after a falling edge (cycle 0) and
  // returns the cycle index where cpu_stall first drops, or -1 on timeout.
  task automatic do_access(input logic ie, input logic [63:0] ia, input logic de,
                           input logic we, input logic [63:0] da, input logic [63:0] wd,
                           input logic [3:0] sel, output int lat, output int errs);
    @(negedge clk);
    isram_e = ie; isram_addr = ia;
    dsram_e = de; dsram_we = we; dsram_addr = da; dsram_wdata = wd; dsram_sel = sel;
    lat = -1; errs = 0;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      av_log[c] = m.awvalid;
      wv_log[c] = m.wvalid;
      if (bus_err) errs++;
      if (!cpu_stall) begin
        lat = c;
        break;
      end
    end
    isram_e = 1'b0; dsram_e = 1'b0; dsram_we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst = 1'b1; isram_e = 1'b1; isram_addr = 64'h8000_0000;
    #2;
    n_checks++; if (cpu_stall !== 1'b1) $display("FAIL reset_stall got %b want 1", cpu_stall); else n_pass++;
    n_checks++; if ({m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready} !== 5'b0)
      $display("FAIL reset_handshakes got %b want 00000", {m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready}); else n_pass++;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err got %b want 0", bus_err); else n_pass++;
    n_checks++; if ({isram_rdata, dsram_rdata} !== 96'h0) $display("FAIL reset_rdata got %h %h want 0 0", isram_rdata, dsram_rdata); else n_pass++;
    @(negedge clk);
    rst = 1'b0; isram_e = 1'b0;
  endtask

  task automatic test_preload;
    int lat, errs;
    logic [63:0] pa [3] = '{64'h8000_0000, 64'h8000_0100, 64'h8000_0108};
    logic [63:0] pd [3] = '{64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF, 64'h5555_6666_7777_8888};
    for (int i = 0; i < 3; i++) begin
      do_access(1'b0, 64'h0, 1'b1, 1'b1, pa[i], pd[i], SEL_D, lat, errs);
      n_checks++; if (lat !== 3) $display("FAIL preload_store%0d_latency got %0d want 3", i, lat); else n_pass++;
    end
  endtask

  task automatic test_fetch;
    int lat, errs;
    do_access(1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'h0, 64'h0, 4'b0, lat, errs);
    n_checks++; if (lat !== 3) $display("FAIL fetch_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (isram_rdata !== 32'h1111_2222) $display("FAIL fetch_inst got %h want 11112222", isram_rdata); else n_pass++;
    n_checks++; if (dsram_rdata !== 64'h0) $display("FAIL fetch_dsram_hold got %h want 0", dsram_rdata); else n_pass++;
  endtask

  task automatic test_store_byte;
    int lat, errs;
    do_access(1'b0, 64'h0, 1'b1, 1'b1, 64'h8000_0103, 64'hAB, SEL_B, lat, errs);
    n_checks++; if (lat !== 3) $display("FAIL sb_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (cap_awaddr !== 64'h8000_0100) $display("FAIL sb_awaddr got %h want 80000100", cap_awaddr); else n_pass++;
    n_checks++; if (cap_wstrb !== 8'h08) $display("FAIL sb_wstrb got %h want 08", cap_wstrb); else n_pass++;
    n_checks++; if (cap_wdata !== 64'hAB00_0000) $display("FAIL sb_wdata got %h want ab000000", cap_wdata); else n_pass++;
    do_access(1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0103, 64'h0, SEL_B, lat, errs);
    n_checks++; if (lat !== 3) $display("FAIL lb_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (dsram_rdata !== 64'h0000_0001_2345_67AB) $display("FAIL lb_rdata got %h want 00000001234567ab", dsram_rdata); else n_pass++;
    n_checks++; if (isram_rdata !== 32'h1111_2222) $display("FAIL lb_isram_hold got %h want 11112222", isram_rdata); else n_pass++;
  endtask

  task automatic test_load_fetch;
    int lat, errs, base;
    base = ar_log.size();
    do_access(1'b1, 64'h8000_0000, 1'b1, 1'b0, 64'h8000_0108, 64'h0, SEL_D, lat, errs);
    n_checks++; if (lat !== 5) $display("FAIL lf_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (dsram_rdata !== 64'h5555_6666_7777_8888) $display("FAIL lf_dsram got %h want 5555666677778888", dsram_rdata); else n_pass++;
    n_checks++; if (isram_rdata !== 32'h3333_4444) $display("FAIL lf_isram got %h want 33334444", isram_rdata); else n_pass++;
    n_checks++; if (ar_log.size() - base !== 2) $display("FAIL lf_ar_count got %0d want 2", ar_log.size() - base); else n_pass++;
    if (ar_log.size() - base >= 2) begin
      n_checks++; if (ar_log[base] !== 64'h8000_0108) $display("FAIL lf_ar0 got %h want 80000108", ar_log[base]); else n_pass++;
      n_checks++; if (ar_log[base+1] !== 64'h8000_0000) $display("FAIL lf_ar1 got %h want 80000000", ar_log[base+1]); else n_pass++;
    end
  endtask

  task automatic test_slow_slave;
    int lat, errs;
    ar_delay = 3; aw_delay = 3; w_delay = 0;
    do_access(1'b1, 64'h8000_0204, 1'b1, 1'b1, 64'h8000_0200, 64'hDEAD_BEEF_CAFE_F00D, SEL_D, lat, errs);
    ar_delay = 0; aw_delay = 0;
    n_checks++; if (lat !== 11) $display("FAIL slow_latency got %0d want 11", lat); else n_pass++;
    n_checks++; if ({av_log[1], wv_log[1]} !== 2'b11) $display("FAIL slow_c1_aw_w got %b want 11", {av_log[1], wv_log[1]}); else n_pass++;
    n_checks++; if ({av_log[2], wv_log[2]} !== 2'b10) $display("FAIL slow_c2_aw_w got %b want 10", {av_log[2], wv_log[2]}); else n_pass++;
    n_checks++; if ({av_log[4], wv_log[4]} !== 2'b10) $display("FAIL slow_c4_aw_w got %b want 10", {av_log[4], wv_log[4]}); else n_pass++;
    n_checks++; if (av_log[5] !== 1'b0) $display("FAIL slow_c5_aw got %b want 0", av_log[5]); else n_pass++;
    n_checks++; if (isram_rdata !== 32'hDEAD_BEEF) $display("FAIL slow_inst got %h want deadbeef", isram_rdata); else n_pass++;
  endtask

  task automatic test_strobe_edges;
    int lat, errs;
    logic [63:0] ta [4] = '{64'h8000_0306, 64'h8000_0300, 64'h8000_0304, 64'h8000_0302};
    logic [3:0]  ts [4] = '{4'b0100, 4'b0000, 4'b0110, 4'b0010};
    logic [63:0] tw [4] = '{64'h1122_3344, 64'h55, 64'hAABB_CCDD, 64'hBEEF};
    logic [7:0]  es [4] = '{8'hC0, 8'h00, 8'hF0, 8'h0C};
    logic [63:0] ew [4] = '{64'h3344_0000_0000_0000, 64'h55, 64'hAABB_CCDD_0000_0000, 64'hBEEF_0000};
    for (int i = 0; i < 4; i++) begin
      do_access(1'b0, 64'h0, 1'b1, 1'b1, ta[i], tw[i], ts[i], lat, errs);
      n_checks++; if (lat !== 3) $display("FAIL strb%0d_latency got %0d want 3", i, lat); else n_pass++;
      n_checks++; if (cap_wstrb !== es[i]) $display("FAIL strb%0d_wstrb got %h want %h", i, cap_wstrb, es[i]); else n_pass++;
      n_checks++; if (cap_wdata !== ew[i]) $display("FAIL strb%0d_wdata got %h want %h", i, cap_wdata, ew[i]); else n_pass++;
      n_checks++; if (cap_awaddr !== 64'h8000_0300) $display("FAIL strb%0d_awaddr got %h want 80000300", i, cap_awaddr); else n_pass++;
    end
  endtask

  task automatic test_bus_err;
    int lat, errs;
    rresp_cfg = 2'b10;
    do_access(1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 64'h0, 4'b0, lat, errs);
    rresp_cfg = 2'b00;
    n_checks++; if (lat !== 3) $display("FAIL err_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (errs !== 1) $display("FAIL err_pulse_cycles got %0d want 1", errs); else n_pass++;
    n_checks++; if (isram_rdata !== 32'h3333_4444) $display("FAIL err_inst got %h want 33334444", isram_rdata); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus_err !== 1'b0) $display("FAIL err_after got %b want 0", bus_err); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat, errs;
    @(negedge clk);
    dsram_e = 1'b1; dsram_we = 1'b0; dsram_addr = 64'h8000_0100; dsram_sel = SEL_D;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if (m.rready !== 1'b1) $display("FAIL rst_mid_in_dr got %b want 1", m.rready); else n_pass++;
    rst = 1'b1; #1;
    n_checks++; if ({m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready} !== 5'b0)
      $display("FAIL rst_mid_handshakes got %b want 00000", {m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready}); else n_pass++;
    n_checks++; if ({isram_rdata, dsram_rdata} !== 96'h0) $display("FAIL rst_mid_rdata got %h %h want 0 0", isram_rdata, dsram_rdata); else n_pass++;
    n_checks++; if (cpu_stall !== 1'b1) $display("FAIL rst_mid_stall got %b want 1", cpu_stall); else n_pass++;
    @(negedge clk);
    rst = 1'b0; dsram_e = 1'b0;
    @(negedge clk); #1;
    n_checks++; if ({m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready, cpu_stall} !== 6'b0)
      $display("FAIL rst_mid_after got %b want 000000", {m.arvalid, m.awvalid, m.wvalid, m.bready, m.rready, cpu_stall}); else n_pass++;
    do_access(1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'h0, 64'h0, 4'b0, lat, errs);
    n_checks++; if (lat !== 3) $display("FAIL rst_mid_fetch_latency got %0d want 3", lat); else n_pass++;
    n_checks++; if (isram_rdata !== 32'h1111_2222) $display("FAIL rst_mid_fetch_inst got %h want 11112222", isram_rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_fetch();
    test_store_byte();
    test_load_fetch();
    test_slow_slave();
    test_strobe_edges();
    test_bus_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
